// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART demo line-echo path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    WAIT_RDY  = 3'd1,
    SEND_CHAR = 3'd2,
    GUARD     = 3'd3
  } echo_state_e;

  localparam logic [7:0] c_ascii_lf    = 8'h0A;
  localparam logic [7:0] c_ascii_cr    = 8'h0D;
  localparam logic [7:0] c_ascii_space = 8'h20;
  localparam logic [7:0] c_ascii_excl  = 8'h21;
  localparam logic [7:0] c_ascii_0     = 8'h30;
  localparam logic [7:0] c_ascii_a_uc  = 8'h41;
  localparam logic [7:0] c_ascii_a_lc  = 8'h61;

  localparam logic [7:0] c_term_default = c_ascii_lf;

endpackage

`default_nettype wire

// File: rtl/line_buf.sv
// ============================================================================
// Module      : line_buf
// Description : DEPTH x 8 RAM, synchronous write, one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buf #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately not reset so this maps onto distributed/block RAM.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/line_echo.sv
// ============================================================================
// Module      : line_echo
// Description : Buffers a received line, then replays it via the TX send/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_echo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  TERM  = c_term_default
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] recv_data,
  input  logic       vald_data,
  input  logic       ready,
  output logic       send,
  output logic [7:0] send_data,
  output logic       busy,
  output logic       drop
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  echo_state_e   state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic          send_q, send_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;
  logic [7:0]    hold_q, hold_d;
  logic          buf_we;
  logic [7:0]    buf_rdata;

  line_buf #(
    .DEPTH (DEPTH)
  ) u_line_buf (
    .CLK   (CLK),
    .we    (buf_we),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (recv_data),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    drop_d   = drop_q;
    hold_d   = hold_q;
    buf_we   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (vald_data) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if ((recv_data == TERM) || (wr_cnt_d == c_depth)) begin
            state_d  = WAIT_RDY;
            rd_idx_d = '0;
          end
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          if (rd_idx_q == wr_cnt_q) begin
            state_d  = COLLECT;
            wr_cnt_d = '0;
          end else begin
            state_d = SEND_CHAR;
          end
        end
      end
      SEND_CHAR: begin
        // RAM output already reflects buf[rd_idx] this cycle; latch it so it holds after send.
        hold_d   = buf_rdata;
        rd_idx_d = rd_idx_q + 1'b1;
        state_d  = GUARD;
      end
      GUARD: begin
        state_d = WAIT_RDY;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    if (vald_data && (state_q != COLLECT)) begin
      drop_d = 1'b1;
    end

    send_d = (state_d == SEND_CHAR);
    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= COLLECT;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      hold_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      send_q   <= send_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
    end
  end

  assign send      = send_q;
  assign send_data = send_q ? buf_rdata : hold_q;
  assign busy      = busy_q;
  assign drop      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_line_echo.sv
// ============================================================================
// Module      : tb_line_echo
// Description : Self-checking bench for line_echo with an echo-byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_echo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] recv_data = 8'h00;
  logic       vald_data = 1'b0;
  logic       ready = 1'b1;
  logic       send;
  logic [7:0] send_data;
  logic       busy;
  logic       drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int snd_count = 0;
  int prev_snd = -100;
  int line_base = 0;
  int snd_cycles[$];
  logic [7:0] expq[$];
  logic [7:0] last_data = 8'h00;

  typedef struct {
    int          len;
    logic [127:0] data;
  } vec_t;

  vec_t tbl[6];

  line_echo #(
    .DEPTH (16),
    .TERM  (8'h0A)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .recv_data (recv_data),
    .vald_data (vald_data),
    .ready     (ready),
    .send      (send),
    .send_data (send_data),
    .busy      (busy),
    .drop      (drop)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every send and checks hold/spacing.
  always @(negedge CLK) begin
    logic [7:0] exp_b;
    if (RST) begin
      last_data = 8'h00;
      prev_snd  = -100;
    end
    if (send === 1'b1) begin
      checks++;
      if (cyc - prev_snd < 3) begin
        failures++;
        $display("FAIL send_spacing: gap=%0d required>=3", cyc - prev_snd);
      end
      prev_snd = cyc;
      snd_cycles.push_back(cyc);
      snd_count++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_send: data=%02h required no send", send_data);
      end else begin
        exp_b = expq.pop_front();
        if (send_data !== exp_b) begin
          failures++;
          $display("FAIL send_data: got=%02h required=%02h", send_data, exp_b);
        end
      end
      last_data = send_data;
    end else if (cyc > 0) begin
      checks++;
      if (send_data !== last_data) begin
        failures++;
        $display("FAIL send_data_hold: got=%02h required=%02h", send_data, last_data);
      end
    end
  end

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives n back-to-back bytes; t returns the cycle the last byte was presented.
  task automatic drive_line(input logic [127:0] d, input int n, output int t);
    line_base = snd_count;
    for (int i = 0; i < n; i++) begin
      tick();
      vald_data = 1'b1;
      recv_data = d[i*8 +: 8];
      expq.push_back(d[i*8 +: 8]);
      t = cyc;
    end
    tick();
    vald_data = 1'b0;
  endtask

  task automatic wait_idle(input int t, input int n, input int extra, input bit timing);
    int k;
    chk("busy_high", {31'd0, busy}, 32'd1);
    k = 0;
    while (busy === 1'b1 && k < 3 * n + 10 + extra) begin
      tick();
      k++;
    end
    chk("busy_fall_timeout", {31'd0, busy}, 32'd0);
    chk("send_count", snd_count - line_base, n);
    if (timing) begin
      chk("return_cycle", cyc, t + 3 * n + 2);
      if (snd_cycles.size() > line_base) chk("first_send_cycle", snd_cycles[line_base], t + 2);
      else chk("first_send_missing", 0, 1);
    end
  endtask

  task automatic wait_sends(input int target, output int at);
    int k;
    k = 0;
    while (snd_count < target && k < 20) begin
      tick();
      k++;
    end
    chk("send_wait_timeout", snd_count, target);
    at = cyc;
  endtask

  initial begin
    logic [127:0] tmp;
    int t;
    int at;
    int r;
    int base;

    tmp = '0; tmp[7:0] = 8'h41; tmp[15:8] = 8'h37; tmp[23:16] = 8'h0A;
    tbl[0] = '{3, tmp};
    tmp = '0; tmp[7:0] = 8'h0A;
    tbl[1] = '{1, tmp};
    tmp = '0;
    for (int i = 0; i < 16; i++) tmp[i*8 +: 8] = 8'h30 + 8'(i);
    tbl[2] = '{16, tmp};
    tmp = '0; tmp[7:0] = 8'h68; tmp[15:8] = 8'h69; tmp[23:16] = 8'h21; tmp[31:24] = 8'h0A;
    tbl[3] = '{4, tmp};
    tmp = '0;
    for (int i = 0; i < 15; i++) tmp[i*8 +: 8] = 8'h61 + 8'(i);
    tmp[127:120] = 8'h0A;
    tbl[4] = '{16, tmp};
    tmp = '0; tmp[7:0] = 8'h35; tmp[15:8] = 8'h0A;
    tbl[5] = '{2, tmp};

    repeat (3) tick();
    RST = 1'b0;
    chk("rst_send", {31'd0, send}, 32'd0);
    chk("rst_send_data", {24'd0, send_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      drive_line(tbl[v].data, tbl[v].len, t);
      wait_idle(t, tbl[v].len, 0, 1'b1);
      chk("table_drop", {31'd0, drop}, 32'd0);
    end

    // Backpressure: stall after the first byte of "AB\n".
    tmp = '0; tmp[7:0] = 8'h41; tmp[15:8] = 8'h42; tmp[23:16] = 8'h0A;
    drive_line(tmp, 3, t);
    wait_sends(line_base + 1, at);
    chk("bp_first_send", at, t + 2);
    ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_no_send", {31'd0, send}, 32'd0);
      chk("bp_hold_data", {24'd0, send_data}, 32'h41);
    end
    ready = 1'b1;
    r = cyc;
    wait_sends(line_base + 2, at);
    chk("bp_resume_cycle", at, r + 1);
    wait_idle(t, 3, 60, 1'b0);

    // Overrun: a byte arriving while echoing must vanish and set drop.
    tmp = '0; tmp[7:0] = 8'h4B; tmp[15:8] = 8'h0A;
    drive_line(tmp, 2, t);
    vald_data = 1'b1;
    recv_data = 8'h55;
    tick();
    vald_data = 1'b0;
    wait_idle(t, 2, 0, 1'b1);
    chk("ovr_drop_set", {31'd0, drop}, 32'd1);
    tmp = '0; tmp[7:0] = 8'h4D; tmp[15:8] = 8'h0A;
    drive_line(tmp, 2, t);
    wait_idle(t, 2, 0, 1'b1);
    chk("ovr_drop_sticky", {31'd0, drop}, 32'd1);

    // Reset during the second SEND_CHAR of "XYZ\n".
    tmp = '0; tmp[7:0] = 8'h58; tmp[15:8] = 8'h59; tmp[23:16] = 8'h5A; tmp[31:24] = 8'h0A;
    drive_line(tmp, 4, t);
    wait_sends(line_base + 2, at);
    base = snd_count;
    RST = 1'b1;
    expq.delete();
    tick();
    chk("mid_rst_send", {31'd0, send}, 32'd0);
    chk("mid_rst_send_data", {24'd0, send_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_drop", {31'd0, drop}, 32'd0);
    RST = 1'b0;
    repeat (20) tick();
    chk("mid_rst_no_more_sends", snd_count, base);
    tmp = '0; tmp[7:0] = 8'h51; tmp[15:8] = 8'h0A;
    drive_line(tmp, 2, t);
    wait_idle(t, 2, 0, 1'b1);

    chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

endmodule

`default_nettype wire
